// File: rtl/cmd_tracker_pkg.sv
// Shared types for the command tracker: opcodes, the queued command record
// and the response-slot state encoding.
package cmd_tracker_pkg;

    localparam int ID_SZ = 4;

    typedef enum logic [1:0] {
        INS = 2'd0,
        DEL = 2'd1,
        QRY = 2'd2
    } opcode;

    typedef struct packed {
        opcode             op;
        logic              mo;
        logic [ID_SZ-1:0]  id;
    } cmd_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO of cmd_t records with registered occupancy flags.
// The head entry is presented combinationally on dout whenever not empty.
module cmd_fifo
    import cmd_tracker_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t din,
    input  logic pop,
    output cmd_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmd_t            mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == (AW+1)'(DEPTH));
    assign empty = (count_r == (AW+1)'(0));

    // Storage array: data only, no reset needed since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= (wr_ptr_r == AW'(DEPTH-1)) ? AW'(0) : wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= (rd_ptr_r == AW'(DEPTH-1)) ? AW'(0) : rd_ptr_r + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cmd_tracker.sv
// Buffers writer commands, executes them in order against an ID-presence
// table and returns hit/miss responses through a single-entry response slot.
module cmd_tracker
    import cmd_tracker_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = ID_SZ
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wrm,
    output logic            wrs,
    input  opcode           wop,
    input  logic            wmo,
    input  logic [ID_W-1:0] wid,
    output logic            rvl,
    input  logic            rrd,
    output opcode           rop,
    output logic [ID_W-1:0] rid,
    output logic            rhit,
    output logic [ID_W:0]   cnt,
    output logic            err
);

    localparam int NIDS = 2**ID_W;

    logic               ready_r;
    logic               push_s;
    logic               exec_s;
    logic               load_s;
    logic               full_s;
    logic               empty_s;
    cmd_t               din_s;
    cmd_t               head_s;

    logic [NIDS-1:0]    tbl_r;
    logic [NIDS-1:0]    tbl_next_s;
    logic [ID_W:0]      cnt_r;
    logic [ID_W:0]      cnt_next_s;
    logic               err_r;
    logic               err_next_s;
    logic               hit_s;

    slot_state_t        slot_r;
    slot_state_t        slot_next_s;
    opcode              rop_r;
    logic [ID_W-1:0]    rid_r;
    logic               rhit_r;

    // ready_r keeps the writer stalled for the first cycle out of reset.
    assign wrs    = ready_r && !full_s && !rst;
    assign push_s = wrm && wrs;
    assign din_s  = '{op: wop, mo: wmo, id: wid};

    // A silent head never waits on the response sink.
    assign exec_s = !empty_s && (!head_s.mo || (slot_r == SLOT_EMPTY) || rrd);
    assign load_s = exec_s && head_s.mo;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (din_s),
        .pop   (exec_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Execute the head command against the presence table.
    always_comb begin
        tbl_next_s = tbl_r;
        cnt_next_s = cnt_r;
        err_next_s = err_r;
        hit_s      = 1'b0;
        if (exec_s) begin
            case (head_s.op)
                INS: begin
                    hit_s = tbl_r[head_s.id];
                    tbl_next_s[head_s.id] = 1'b1;
                    if (!hit_s) begin
                        cnt_next_s = cnt_r + (ID_W+1)'(1);
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                end
                DEL: begin
                    hit_s = tbl_r[head_s.id];
                    tbl_next_s[head_s.id] = 1'b0;
                    if (hit_s) begin
                        cnt_next_s = cnt_r - (ID_W+1)'(1);
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                end
                QRY: begin
                    hit_s = tbl_r[head_s.id];
                end
                default: begin
                    hit_s      = 1'b0;
                    err_next_s = 1'b1;
                end
            endcase
        end else begin
            hit_s = 1'b0;
        end
    end

    // Response slot next-state: a new load always wins over a drain.
    always_comb begin
        slot_next_s = slot_r;
        case (slot_r)
            SLOT_EMPTY: begin
                if (load_s) begin
                    slot_next_s = SLOT_FULL;
                end else begin
                    slot_next_s = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (load_s) begin
                    slot_next_s = SLOT_FULL;
                end else if (rrd) begin
                    slot_next_s = SLOT_EMPTY;
                end else begin
                    slot_next_s = SLOT_FULL;
                end
            end
            default: slot_next_s = SLOT_EMPTY;
        endcase
    end

    // State registers: table, counters, slot and response payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r <= 1'b0;
            tbl_r   <= '0;
            cnt_r   <= '0;
            err_r   <= 1'b0;
            slot_r  <= SLOT_EMPTY;
            rop_r   <= DEL;
            rid_r   <= '0;
            rhit_r  <= 1'b0;
        end else begin
            ready_r <= 1'b1;
            tbl_r   <= tbl_next_s;
            cnt_r   <= cnt_next_s;
            err_r   <= err_next_s;
            slot_r  <= slot_next_s;
            if (load_s) begin
                rop_r  <= head_s.op;
                rid_r  <= head_s.id;
                rhit_r <= hit_s;
            end
        end
    end

    assign rvl  = (slot_r == SLOT_FULL);
    assign rop  = rop_r;
    assign rid  = rid_r;
    assign rhit = rhit_r;
    assign cnt  = cnt_r;
    assign err  = err_r;

endmodule

// File: tb/tb_cmd_tracker.sv
// Directed self-checking bench for cmd_tracker with hand-computed expectations.
module tb_cmd_tracker;
    import cmd_tracker_pkg::*;

    logic         clk;
    logic         rst;
    logic         wrm;
    logic         wrs;
    opcode        wop;
    logic         wmo;
    logic [3:0]   wid;
    logic         rvl;
    logic         rrd;
    opcode        rop;
    logic [3:0]   rid;
    logic         rhit;
    logic [4:0]   cnt;
    logic         err;

    int checks = 0;
    int errors = 0;
    int got;
    logic acc;

    cmd_tracker #(.FIFO_DEPTH(4), .ID_W(4)) dut (
        .clk(clk), .rst(rst), .wrm(wrm), .wrs(wrs), .wop(wop), .wmo(wmo),
        .wid(wid), .rvl(rvl), .rrd(rrd), .rop(rop), .rid(rid), .rhit(rhit),
        .cnt(cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push one command (assumes wrs is high), then drop wrm.
    task automatic send(input opcode op, input logic mo, input logic [3:0] id);
        wrm = 1'b1; wop = op; wmo = mo; wid = id;
        tick();
        wrm = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wrm = 1'b0; wop = INS; wmo = 1'b0; wid = 4'd0; rrd = 1'b1;
        tick();
        tick();
        chk("rst_rvl", rvl, 1'b0);
        chk("rst_rop", rop, DEL);
        chk("rst_rid", rid, 4'd0);
        chk("rst_rhit", rhit, 1'b0);
        chk("rst_cnt", cnt, 5'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_wrs", wrs, 1'b0);
        rst = 1'b0;
        tick();
        chk("post_rst_wrs", wrs, 1'b1);

        // 1: INS id3 twice with responses
        send(INS, 1'b1, 4'd3);
        chk("t1_lat_rvl", rvl, 1'b0);
        tick();
        chk("t1_rvl", rvl, 1'b1);
        chk("t1_rop", rop, INS);
        chk("t1_rid", rid, 4'd3);
        chk("t1_rhit", rhit, 1'b0);
        chk("t1_cnt", cnt, 5'd1);
        tick();
        chk("t1_rvl_drop", rvl, 1'b0);
        send(INS, 1'b1, 4'd3);
        tick();
        chk("t1b_rvl", rvl, 1'b1);
        chk("t1b_rhit", rhit, 1'b1);
        chk("t1b_cnt", cnt, 5'd1);
        tick();
        chk("t1b_rvl_drop", rvl, 1'b0);

        // 2: silent INS id5 then QRY id5 back-to-back
        wrm = 1'b1; wop = INS; wmo = 1'b0; wid = 4'd5;
        tick();
        wop = QRY; wmo = 1'b1;
        tick();
        wrm = 1'b0;
        chk("t2_silent_rvl", rvl, 1'b0);
        chk("t2_cnt", cnt, 5'd2);
        tick();
        chk("t2_rvl", rvl, 1'b1);
        chk("t2_rop", rop, QRY);
        chk("t2_rid", rid, 4'd5);
        chk("t2_rhit", rhit, 1'b1);
        tick();
        chk("t2_single_resp", rvl, 1'b0);
        send(DEL, 1'b0, 4'd5);
        tick();
        chk("t2_del_cnt", cnt, 5'd1);
        chk("t2_del_rvl", rvl, 1'b0);

        // 3: backpressure fills slot + FIFO, then drains in order
        rrd = 1'b0;
        wrm = 1'b1; wop = INS; wmo = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wid = 4'(8 + k);
            chk("t3_wrs_open", wrs, 1'b1);
            tick();
        end
        wid = 4'd13;
        chk("t3_wrs_full", wrs, 1'b0);
        chk("t3_slot_rvl", rvl, 1'b1);
        chk("t3_slot_rid", rid, 4'd8);
        chk("t3_cnt_stall", cnt, 5'd2);
        tick();
        chk("t3_wrs_held", wrs, 1'b0);
        chk("t3_rid_held", rid, 4'd8);
        rrd = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
            if (rvl) begin
                chk("t3_order_rid", rid, 32'(8 + got));
                chk("t3_order_rhit", rhit, 1'b0);
                got++;
            end
            acc = wrm && wrs;
            tick();
            if (acc) wrm = 1'b0;
        end
        chk("t3_resp_count", got, 6);
        chk("t3_drained", rvl, 1'b0);
        chk("t3_cnt", cnt, 5'd7);

        // 4: silent command bypasses a blocked slot
        rrd = 1'b0;
        send(INS, 1'b1, 4'd14);
        tick();
        chk("t4_slot_rid", rid, 4'd14);
        chk("t4_cnt_a", cnt, 5'd8);
        send(INS, 1'b0, 4'd7);
        tick();
        chk("t4_cnt_b", cnt, 5'd9);
        chk("t4_rvl", rvl, 1'b1);
        chk("t4_rid", rid, 4'd14);
        chk("t4_rop", rop, INS);
        chk("t4_rhit", rhit, 1'b0);
        rrd = 1'b1;
        tick();
        chk("t4_rvl_drop", rvl, 1'b0);

        // 5: illegal opcode sets sticky err
        chk("t5_err_pre", err, 1'b0);
        send(opcode'(2'd3), 1'b1, 4'd3);
        tick();
        chk("t5_rvl", rvl, 1'b1);
        chk("t5_rop", rop, 2'd3);
        chk("t5_rhit", rhit, 1'b0);
        chk("t5_cnt", cnt, 5'd9);
        chk("t5_err", err, 1'b1);
        tick();
        send(QRY, 1'b1, 4'd3);
        tick();
        chk("t5_table_kept", rhit, 1'b1);
        chk("t5_err_sticky", err, 1'b1);
        tick();

        // 6: reset with FIFO 3 deep and response pending
        rrd = 1'b0;
        wrm = 1'b1; wop = QRY; wmo = 1'b1;
        wid = 4'd1; tick();
        wid = 4'd2; tick();
        wid = 4'd4; tick();
        wid = 4'd6; tick();
        wrm = 1'b0;
        chk("t6_pre_rvl", rvl, 1'b1);
        chk("t6_pre_rid", rid, 4'd1);
        rst = 1'b1;
        tick();
        chk("t6_rvl", rvl, 1'b0);
        chk("t6_cnt", cnt, 5'd0);
        chk("t6_err", err, 1'b0);
        chk("t6_wrs_low", wrs, 1'b0);
        rst = 1'b0;
        rrd = 1'b1;
        tick();
        chk("t6_wrs_high", wrs, 1'b1);
        chk("t6_fifo_dropped", rvl, 1'b0);
        send(QRY, 1'b1, 4'd3);
        tick();
        chk("t6_qry_rvl", rvl, 1'b1);
        chk("t6_qry_rhit", rhit, 1'b0);
        chk("t6_qry_cnt", cnt, 5'd0);
        tick();
        chk("t6_idle", rvl, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
